// File: rtl/branch_redirect_ctrl_pkg.sv
// Shared front-end control definitions: redirect sequencer states, flush levels
// and branch classification used across the pipeline control blocks.
package branch_redirect_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_DS = 2'd1,
    PEND    = 2'd2
  } redirect_state_t;

  localparam logic FlushEnable  = 1'b1;
  localparam logic FlushDisable = 1'b0;

  typedef enum logic [3:0] {
    BR_NONE = 4'd0,
    BR_BEQ  = 4'd1,
    BR_BNE  = 4'd2,
    BR_BLEZ = 4'd3,
    BR_BGTZ = 4'd4,
    BR_BLTZ = 4'd5,
    BR_BGEZ = 4'd6,
    BR_J    = 4'd7,
    BR_JAL  = 4'd8,
    BR_JR   = 4'd9,
    BR_JALR = 4'd10
  } BranchType;

  function automatic logic is_unconditional(input BranchType bt);
    return (bt == BR_J) || (bt == BR_JAL) || (bt == BR_JR) || (bt == BR_JALR);
  endfunction

endpackage

// File: rtl/branch_redirect_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         clear,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/branch_redirect_ctrl.sv
// Front-end redirect sequencer: arbitrates MEM redirects against EXE branch
// resolution, protects the delay slot, and holds the redirect until IF accepts.
module branch_redirect_ctrl
  import branch_redirect_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             EXE_BranchValid,
  input  logic             EXE_BranchTaken,
  input  logic [31:0]      EXE_Target,
  input  logic             EXE_Stall,
  input  logic             ID_DSValid,
  input  logic             IF_DSFetched,
  input  logic             IF_Ready,
  input  logic             MEM_Redirect,
  input  logic [31:0]      MEM_RedirectPC,
  output logic             PC_RedirectValid,
  output logic [31:0]      PC_RedirectTarget,
  output logic             IF_Flush,
  output logic             ID_Flush,
  output logic             EXE_Flush,
  output logic             Ctrl_Busy,
  output logic [CNT_W-1:0] Perf_TakenCnt,
  output logic [CNT_W-1:0] Perf_StallCnt
);

  redirect_state_t state_q, state_d;
  logic [31:0]     target_q, target_d;

  logic        redir_valid;
  logic [31:0] redir_target;
  logic        if_flush, id_flush, exe_flush;
  logic        taken_inc;
  logic        stall_inc;
  logic        accept;

  assign accept    = EXE_BranchValid && EXE_BranchTaken && !EXE_Stall;
  assign stall_inc = (state_q == WAIT_DS) || (state_q == PEND);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= IDLE;
      target_q <= '0;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    target_d     = target_q;
    redir_valid  = 1'b0;
    redir_target = '0;
    if_flush     = FlushDisable;
    id_flush     = FlushDisable;
    exe_flush    = FlushDisable;
    taken_inc    = 1'b0;

    if (MEM_Redirect) begin
      // MEM overrides everything; any held branch target is simply overwritten.
      redir_valid  = 1'b1;
      redir_target = MEM_RedirectPC;
      if_flush     = FlushEnable;
      id_flush     = FlushEnable;
      exe_flush    = FlushEnable;
      if (IF_Ready) begin
        state_d = IDLE;
      end else begin
        state_d  = PEND;
        target_d = MEM_RedirectPC;
      end
    end else begin
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            taken_inc = 1'b1;
            target_d  = EXE_Target;
            if (ID_DSValid) begin
              // Delay slot already safe in ID: only the IF instruction is wrong-path.
              redir_valid  = 1'b1;
              redir_target = EXE_Target;
              if_flush     = FlushEnable;
              state_d      = IF_Ready ? IDLE : PEND;
            end else begin
              state_d = WAIT_DS;
            end
          end
        end
        WAIT_DS: begin
          if (IF_DSFetched) begin
            state_d = PEND;
          end
        end
        PEND: begin
          redir_valid  = 1'b1;
          redir_target = target_q;
          if_flush     = FlushEnable;
          if (IF_Ready) begin
            state_d = IDLE;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // Combinational outputs are gated so reset silences them within the same cycle.
  assign PC_RedirectValid  = resetn && redir_valid;
  assign PC_RedirectTarget = resetn ? redir_target : '0;
  assign IF_Flush          = resetn && if_flush;
  assign ID_Flush          = resetn && id_flush;
  assign EXE_Flush         = resetn && exe_flush;
  assign Ctrl_Busy         = resetn && (state_q != IDLE);

  sat_counter #(.W(CNT_W)) u_taken_cnt (
    .clk   (clk),
    .rst_n (resetn),
    .inc   (taken_inc),
    .clear (1'b0),
    .count (Perf_TakenCnt)
  );

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (resetn),
    .inc   (stall_inc),
    .clear (1'b0),
    .count (Perf_StallCnt)
  );

endmodule
